ps_sobel: RTL



---
 rtl/ps_sobel.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps_sobel.sv
// ps_sobel: 3x3 Sobel edge-magnitude stage on the 4-bit intensity of an RGB444 pixel stream.
// Build option SOBEL_THRESH_EN binarizes the magnitude against THRESHOLD instead of scaling it.
module ps_sobel #(
  parameter int         DATA_WIDTH   = 12,
  parameter int         LINE_WIDTH   = 640,
  parameter int         FRAME_HEIGHT = 480,
  parameter logic [6:0] THRESHOLD    = 7'd40
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_req,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid
);

  localparam int XW = $clog2(LINE_WIDTH);
  localparam int YW = $clog2(FRAME_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(LINE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);

  // A 3x3 window needs at least three columns and rows; magnitudes never exceed 120.
  if (DATA_WIDTH != 12 || LINE_WIDTH < 3 || FRAME_HEIGHT < 3 || THRESHOLD > 7'd120)
  begin : g_param_check
    $error("ps_sobel: unsupported parameter set");
  end

  // Input position, frame mode and request
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          mode_q, mode_d;
  logic          req_q, req_d;
  logic          frame_start;
  logic          pix_mode;
  logic [3:0]    pix_int;

  // Line buffers (row y-1 and row y-2) with registered read ports
  logic [3:0] lb1_mem [LINE_WIDTH];
  logic [3:0] lb2_mem [LINE_WIDTH];
  logic [3:0] lb1_rd_q;
  logic [3:0] lb2_rd_q;

  // Stage 1: newest column and pixel context
  logic                  s1_valid_q, s1_valid_d;
  logic [XW-1:0]         s1_x_q, s1_x_d;
  logic [YW-1:0]         s1_y_q, s1_y_d;
  logic                  s1_mode_q, s1_mode_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic [3:0]            s1_cur_q, s1_cur_d;

  // Window: two older columns, packed {top, mid, bottom}
  logic [11:0] col0_q, col0_d;
  logic [11:0] col1_q, col1_d;
  logic [11:0] col2;

  // Stage 2: gradients
  logic                  s2_valid_q, s2_valid_d;
  logic signed [7:0]     s2_gx_q, s2_gx_d;
  logic signed [7:0]     s2_gy_q, s2_gy_d;
  logic                  s2_border_q, s2_border_d;
  logic                  s2_mode_q, s2_mode_d;
  logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;

  // Stage 3: output register
  logic                  o_valid_q, o_valid_d;
  logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
  logic [6:0]            abs_gx;
  logic [6:0]            abs_gy;
  logic [6:0]            mag;
  logic [DATA_WIDTH-1:0] edge_pix;
`ifndef SOBEL_THRESH_EN
  logic [3:0]            nib;
`endif

  function automatic logic [7:0] tri_sum(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] c);
    return 8'(a) + {3'b000, b, 1'b0} + 8'(c);
  endfunction

  always_comb begin
    frame_start = (x_q == '0) && (y_q == '0);
    pix_mode    = frame_start ? i_enable : mode_q;
    pix_int     = i_data[DATA_WIDTH-1 -: 4];
    req_d       = 1'b1;
    x_d         = x_q;
    y_d         = y_q;
    mode_d      = mode_q;
    if (i_valid) begin
      mode_d = pix_mode;
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Read-first at the same address: the registered read returns the previous row.
  always_ff @(posedge i_clk) begin
    if (i_valid) begin
      lb1_rd_q     <= lb1_mem[x_q];
      lb2_rd_q     <= lb2_mem[x_q];
      lb1_mem[x_q] <= pix_int;
    end
  end

  // The y-2 row is filled one cycle later from the y-1 read data.
  always_ff @(posedge i_clk) begin
    if (s1_valid_q) begin
      lb2_mem[s1_x_q] <= lb1_rd_q;
    end
  end

  always_comb begin
    s1_valid_d = i_valid;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    s1_mode_d  = s1_mode_q;
    s1_data_d  = s1_data_q;
    s1_cur_d   = s1_cur_q;
    if (i_valid) begin
      s1_x_d    = x_q;
      s1_y_d    = y_q;
      s1_mode_d = pix_mode;
      s1_data_d = i_data;
      s1_cur_d  = pix_int;
    end
  end

  always_comb begin
    col2        = {lb2_rd_q, lb1_rd_q, s1_cur_q};
    s2_valid_d  = s1_valid_q;
    col0_d      = col0_q;
    col1_d      = col1_q;
    s2_gx_d     = s2_gx_q;
    s2_gy_d     = s2_gy_q;
    s2_border_d = s2_border_q;
    s2_mode_d   = s2_mode_q;
    s2_data_d   = s2_data_q;
    if (s1_valid_q) begin
      col0_d      = col1_q;
      col1_d      = col2;
      s2_gx_d     = tri_sum(col2[11:8], col2[7:4], col2[3:0])
                  - tri_sum(col0_q[11:8], col0_q[7:4], col0_q[3:0]);
      s2_gy_d     = tri_sum(col0_q[3:0], col1_q[3:0], col2[3:0])
                  - tri_sum(col0_q[11:8], col1_q[11:8], col2[11:8]);
      s2_border_d = (s1_x_q < XW'(2)) || (s1_y_q < YW'(2));
      s2_mode_d   = s1_mode_q;
      s2_data_d   = s1_data_q;
    end
  end

  always_comb begin
    abs_gx = s2_gx_q[7] ? 7'(-s2_gx_q) : 7'(s2_gx_q);
    abs_gy = s2_gy_q[7] ? 7'(-s2_gy_q) : 7'(s2_gy_q);
    mag    = abs_gx + abs_gy;
`ifdef SOBEL_THRESH_EN
    edge_pix = (mag >= THRESHOLD) ? 12'hFFF : 12'h000;
`else
    nib      = 4'(mag >> 3);
    edge_pix = {nib, nib, nib};
`endif
    o_valid_d = s2_valid_q;
    o_data_d  = o_data_q;
    if (s2_valid_q) begin
      if (s2_mode_q) begin
        o_data_d = s2_border_q ? '0 : edge_pix;
      end else begin
        o_data_d = s2_data_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_q         <= '0;
      y_q         <= '0;
      mode_q      <= 1'b0;
      req_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_mode_q   <= 1'b0;
      s1_data_q   <= '0;
      s1_cur_q    <= '0;
      col0_q      <= '0;
      col1_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_gx_q     <= '0;
      s2_gy_q     <= '0;
      s2_border_q <= 1'b1;
      s2_mode_q   <= 1'b0;
      s2_data_q   <= '0;
      o_valid_q   <= 1'b0;
      o_data_q    <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      mode_q      <= mode_d;
      req_q       <= req_d;
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s1_mode_q   <= s1_mode_d;
      s1_data_q   <= s1_data_d;
      s1_cur_q    <= s1_cur_d;
      col0_q      <= col0_d;
      col1_q      <= col1_d;
      s2_valid_q  <= s2_valid_d;
      s2_gx_q     <= s2_gx_d;
      s2_gy_q     <= s2_gy_d;
      s2_border_q <= s2_border_d;
      s2_mode_q   <= s2_mode_d;
      s2_data_q   <= s2_data_d;
      o_valid_q   <= o_valid_d;
      o_data_q    <= o_data_d;
    end
  end

  assign o_req   = req_q;
  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;

endmodule
